euclid_fold_ctrl: RTL and testbench

- Sequencer for the folded 4-cell modified-Euclidean key-equation array in the RS decoder.
- Each codeword block is recirculated NPASS times through the cell chain.
- Per block, the controller:
  - clears the array;
  - drives the array's count enable (start_cnt) and input/feedback mux select (feedback_sel);
  - tracks pass number;
  - flags the final-pass output window to the Chien/Forney stage.
- Sits between the syndrome unit and the array.

---
 rtl/euclid_fold_ctrl_if.sv | 30 +++
 rtl/euclid_fold_ctrl.sv | 133 +++++++++++++
 tb/tb_euclid_fold_ctrl.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/euclid_fold_ctrl_if.sv
// Handshake bundle between the key-equation array sequencer and its surroundings.
// The master side is the controller; the slave side is whatever drives blk_start/hold.
interface euclid_fold_ctrl_if #(
   parameter int PW = 2
);
   logic          blk_start;
   logic          hold;
   logic          start_cnt;
   logic          feedback_sel;
   logic          arr_rst_n;
   logic          in_ready;
   logic          res_valid;
   logic          res_first;
   logic [PW-1:0] pass_idx;
   logic          busy;
   logic          done;
   logic          overrun;

   modport master (
      input  blk_start, hold,
      output start_cnt, feedback_sel, arr_rst_n, in_ready, res_valid, res_first,
             pass_idx, busy, done, overrun
   );

   modport slave (
      output blk_start, hold,
      input  start_cnt, feedback_sel, arr_rst_n, in_ready, res_valid, res_first,
             pass_idx, busy, done, overrun
   );
endinterface

// File: rtl/euclid_fold_ctrl.sv
// Sequencer for the folded modified-Euclidean key-equation array: clears the array,
// recirculates each block NPASS times and flags the final-pass output window.
module euclid_fold_ctrl #(
   parameter int NPASS    = 4,
   parameter int PASS_CYC = 33,
   parameter int PW       = 2,
   parameter int CW       = 10
) (
   input  logic                clk,
   input  logic                reset,
   euclid_fold_ctrl_if.master  bus
);

   typedef enum logic [2:0] {IDLE, CLR, LOAD, ITER, OUT, DONE} state_t;

   localparam int TOTAL = NPASS * PASS_CYC;

   state_t        state;
   logic [CW-1:0] cyc_cnt;
   logic [CW-1:0] pass_cyc;
   logic [PW-1:0] pass_q;
   logic          fb_q;
   logic          arr_q;
   logic          busy_q;
   logic          done_q;
   logic          ovr_q;
   logic          active;
   logic          en;
   logic          pass_end;
   logic          blk_end;

   // hold must stop the array in the same cycle, so the enable family stays combinational
   assign active   = (state == LOAD) || (state == ITER) || (state == OUT);
   assign en       = active & ~bus.hold;
   assign pass_end = (pass_cyc == CW'(PASS_CYC - 1));
   assign blk_end  = (cyc_cnt == CW'(TOTAL - 1));

   assign bus.start_cnt    = en;
   assign bus.in_ready     = (state == LOAD) & en;
   assign bus.res_valid    = (state == OUT) & en;
   assign bus.res_first    = (state == OUT) & en & (pass_cyc == '0);
   assign bus.feedback_sel = fb_q;
   assign bus.arr_rst_n    = arr_q;
   assign bus.pass_idx     = pass_q;
   assign bus.busy         = busy_q;
   assign bus.done         = done_q;
   assign bus.overrun      = ovr_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         cyc_cnt  <= '0;
         pass_cyc <= '0;
         pass_q   <= '0;
         fb_q     <= 1'b1;
         arr_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         ovr_q    <= 1'b0;
      end else begin
         arr_q  <= 1'b1;
         done_q <= 1'b0;
         ovr_q  <= bus.blk_start & busy_q;
         case (state)
            IDLE: begin
               fb_q     <= 1'b1;
               busy_q   <= 1'b0;
               pass_q   <= '0;
               cyc_cnt  <= '0;
               pass_cyc <= '0;
               if (bus.blk_start) begin
                  state  <= CLR;
                  busy_q <= 1'b1;
                  arr_q  <= 1'b0;
               end
            end
            CLR: begin
               state <= LOAD;
            end
            LOAD: begin
               if (en) begin
                  cyc_cnt <= cyc_cnt + CW'(1);
                  if (pass_end) begin
                     pass_cyc <= '0;
                     pass_q   <= PW'(1);
                     fb_q     <= 1'b0;
                     state    <= (NPASS == 2) ? OUT : ITER;
                  end else begin
                     pass_cyc <= pass_cyc + CW'(1);
                  end
               end
            end
            ITER: begin
               if (en) begin
                  cyc_cnt <= cyc_cnt + CW'(1);
                  if (pass_end) begin
                     pass_cyc <= '0;
                     pass_q   <= pass_q + PW'(1);
                     if (pass_q == PW'(NPASS - 2)) begin
                        state <= OUT;
                     end
                  end else begin
                     pass_cyc <= pass_cyc + CW'(1);
                  end
               end
            end
            OUT: begin
               if (en) begin
                  if (blk_end) begin
                     state    <= DONE;
                     done_q   <= 1'b1;
                     fb_q     <= 1'b1;
                     cyc_cnt  <= '0;
                     pass_cyc <= '0;
                  end else begin
                     cyc_cnt  <= cyc_cnt + CW'(1);
                     pass_cyc <= pass_cyc + CW'(1);
                  end
               end
            end
            DONE: begin
               state  <= IDLE;
               busy_q <= 1'b0;
               pass_q <= '0;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_euclid_fold_ctrl.sv
// Bench for euclid_fold_ctrl: an NPASS=4 and an NPASS=2 instance share directed stimulus and
// are checked every cycle against a block-level model driven by enabled-cycle counts.
module tb_euclid_fold_ctrl;

   localparam int PC = 33;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic blk_start = 1'b0;
   logic hold = 1'b0;

   int tests = 0;
   int failures = 0;
   int cyc = 0;

   euclid_fold_ctrl_if #(.PW(2)) if4 ();
   euclid_fold_ctrl_if #(.PW(1)) if2 ();

   assign if4.blk_start = blk_start;
   assign if4.hold      = hold;
   assign if2.blk_start = blk_start;
   assign if2.hold      = hold;

   euclid_fold_ctrl #(.NPASS(4), .PASS_CYC(PC), .PW(2), .CW(10)) dut4 (
      .clk(clk), .reset(reset), .bus(if4.master));
   euclid_fold_ctrl #(.NPASS(2), .PASS_CYC(PC), .PW(1), .CW(7)) dut2 (
      .clk(clk), .reset(reset), .bus(if2.master));

   always #5 clk = ~clk;

   // model: phase 0 idle, 1 clear, 2 counting enabled cycles, 3 done pulse
   int   np [2] = '{4, 2};
   int   ph [2] = '{0, 0};
   int   en_cnt [2] = '{0, 0};
   logic ov [2] = '{1'b0, 1'b0};
   logic rp [2] = '{1'b1, 1'b1};

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   function automatic logic [10:0] model_vec(input int n, input int p, input int e,
                                             input logic hld, input logic rpend, input logic ovr);
      logic act, sc, fb, arr, ir, rv, rf;
      logic [1:0] pidx;
      act  = (p == 2);
      sc   = act && !hld;
      fb   = !(act && e >= PC);
      arr  = !(p == 1 || rpend);
      ir   = sc && e < PC;
      rv   = sc && e >= (n - 1) * PC;
      rf   = rv && e == (n - 1) * PC;
      pidx = act ? 2'(e / PC) : 2'd0;
      return {sc, fb, arr, ir, rv, rf, (p != 0), (p == 3), ovr, pidx};
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < 2; k++) begin
            ph[k] <= 0; en_cnt[k] <= 0; ov[k] <= 1'b0; rp[k] <= 1'b1;
         end
      end else begin
         for (int k = 0; k < 2; k++) begin
            rp[k] <= 1'b0;
            ov[k] <= blk_start && ph[k] != 0;
            case (ph[k])
               0: if (blk_start) ph[k] <= 1;
               1: begin ph[k] <= 2; en_cnt[k] <= 0; end
               2: if (!hold) begin
                     if (en_cnt[k] + 1 == np[k] * PC) begin
                        ph[k] <= 3; en_cnt[k] <= 0;
                     end else begin
                        en_cnt[k] <= en_cnt[k] + 1;
                     end
                  end
               default: ph[k] <= 0;
            endcase
         end
      end
   end

   always @(negedge clk) begin
      logic [10:0] obs, exp, mask;
      obs  = {if4.start_cnt, if4.feedback_sel, if4.arr_rst_n, if4.in_ready, if4.res_valid,
              if4.res_first, if4.busy, if4.done, if4.overrun, if4.pass_idx};
      exp  = model_vec(np[0], ph[0], en_cnt[0], hold, rp[0], ov[0]);
      mask = (ph[0] == 2) ? 11'h7FF : 11'h7FC;
      check_output("model_npass4", 32'(obs & mask), 32'(exp & mask));
      obs  = {if2.start_cnt, if2.feedback_sel, if2.arr_rst_n, if2.in_ready, if2.res_valid,
              if2.res_first, if2.busy, if2.done, if2.overrun, 1'b0, if2.pass_idx};
      exp  = model_vec(np[1], ph[1], en_cnt[1], hold, rp[1], ov[1]);
      mask = (ph[1] == 2) ? 11'h7FF : 11'h7FC;
      check_output("model_npass2", 32'(obs & mask), 32'(exp & mask));
   end

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic advance(input int n);
      while (cyc < n) tick();
   endtask

   task automatic at_cycle(input int n);
      advance(n);
      @(negedge clk);
   endtask

   task automatic apply_stimulus();
      blk_start = 1'b1;
      cyc = 0;
      tick();
      blk_start = 1'b0;
   endtask

   task automatic wait_idle();
      bit ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (!if4.busy && !if2.busy) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      check_output("idle_timeout", 32'(ok), 32'd1);
      tick();
   endtask

   task automatic nominal_pins(input string tag);
      at_cycle(1);   check_output({tag, "_clr_arr"}, 32'(if4.arr_rst_n), 32'd0);
      at_cycle(2);   check_output({tag, "_in_ready_first"}, 32'(if4.in_ready), 32'd1);
      at_cycle(34);  check_output({tag, "_in_ready_last"}, 32'(if4.in_ready), 32'd1);
      at_cycle(35);  check_output({tag, "_fb_iter"}, 32'(if4.feedback_sel), 32'd0);
                     check_output({tag, "_n2_pass_out"}, 32'(if2.pass_idx), 32'd1);
      at_cycle(68);  check_output({tag, "_pass2"}, 32'(if4.pass_idx), 32'd2);
                     check_output({tag, "_n2_done"}, 32'(if2.done), 32'd1);
      at_cycle(101); check_output({tag, "_res_first"}, 32'(if4.res_first), 32'd1);
                     check_output({tag, "_pass_out"}, 32'(if4.pass_idx), 32'd3);
      at_cycle(133); check_output({tag, "_res_last"}, 32'(if4.res_valid), 32'd1);
      at_cycle(134); check_output({tag, "_done"}, 32'(if4.done), 32'd1);
      at_cycle(135); check_output({tag, "_idle_busy"}, 32'(if4.busy), 32'd0);
   endtask

   initial begin
      #1 reset = 1'b1;
      @(negedge clk);
      check_output("reset_arr", 32'(if4.arr_rst_n), 32'd0);
      check_output("reset_fb", 32'(if4.feedback_sel), 32'd1);
      check_output("reset_busy", 32'(if4.busy), 32'd0);
      tick();
      reset = 1'b0;
      tick();
      tick();

      $display("[TB] nominal block");
      apply_stimulus();
      nominal_pins("nom");
      wait_idle();

      $display("[TB] hold for five cycles");
      apply_stimulus();
      advance(50);
      hold = 1'b1;
      at_cycle(52);
      check_output("hold_start_cnt", 32'(if4.start_cnt), 32'd0);
      check_output("hold_pass", 32'(if4.pass_idx), 32'd1);
      advance(55);
      hold = 1'b0;
      at_cycle(105); check_output("hold_res_before", 32'(if4.res_valid), 32'd0);
      at_cycle(106); check_output("hold_res_first", 32'(if4.res_first), 32'd1);
      at_cycle(139); check_output("hold_done", 32'(if4.done), 32'd1);
      wait_idle();

      $display("[TB] overrun while busy");
      apply_stimulus();
      advance(80);
      blk_start = 1'b1;
      tick();
      blk_start = 1'b0;
      at_cycle(81);  check_output("ovr_pulse", 32'(if4.overrun), 32'd1);
      at_cycle(134); check_output("ovr_done", 32'(if4.done), 32'd1);
      wait_idle();

      $display("[TB] reset during final pass");
      apply_stimulus();
      advance(110);
      reset = 1'b1;
      at_cycle(110);
      check_output("rst_res_valid", 32'(if4.res_valid), 32'd0);
      check_output("rst_busy", 32'(if4.busy), 32'd0);
      check_output("rst_arr", 32'(if4.arr_rst_n), 32'd0);
      check_output("rst_fb", 32'(if4.feedback_sel), 32'd1);
      tick();
      tick();
      reset = 1'b0;
      tick();
      wait_idle();
      apply_stimulus();
      nominal_pins("post_rst");
      wait_idle();

      $display("[TB] back-to-back starts");
      apply_stimulus();
      advance(134);
      blk_start = 1'b1;
      tick();
      at_cycle(135);
      check_output("b2b_ovr_from_done", 32'(if4.overrun), 32'd1);
      tick();
      blk_start = 1'b0;
      at_cycle(136);
      check_output("b2b_no_ovr", 32'(if4.overrun), 32'd0);
      check_output("b2b_clr", 32'(if4.arr_rst_n), 32'd0);
      check_output("b2b_busy", 32'(if4.busy), 32'd1);
      wait_idle();

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule
